// File: rtl/clint_pkg.sv
// Shared constants for the core-local interruptor: register word indices,
// ctrl/status bit positions and timer reset values.
package clint_pkg;

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_STATUS      = 3'd5
    } reg_idx_t;

    typedef logic [15:0] presc_t;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_EDGE_BIT   = 1;
    localparam int unsigned STATUS_PEND_BIT = 0;

    localparam logic [63:0] MTIME_RST    = '0;
    localparam logic [63:0] MTIMECMP_RST = '1;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for an asynchronous interrupt line plus a rising-edge
// detector that always follows the synchronized level.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: prescaled 64-bit mtime/mtimecmp timer interrupt and
// a synchronized external interrupt with level/edge modes, on a simple bus.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq_in,
    input  logic        ext_ack,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        ei,
    output logic        ti
);

    localparam presc_t PRESCALE_MAX = presc_t'(PRESCALE - 1);

    logic [2:0]  idx;
    logic        wr_en;
    logic        rd_en;
    logic        addr_unused;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic [31:0] mtime_lo_next;
    logic [31:0] mtime_hi_next;
    presc_t      presc;
    logic        tick;
    logic [1:0]  ctrl;
    logic        en;
    logic        edge_mode;
    logic        pending;
    logic        pend_next;
    logic        pend_clr;
    logic        ext_level;
    logic        ext_rise;
    logic [31:0] rd_data;

    assign idx         = req_addr[4:2];
    assign addr_unused = &req_addr[1:0];
    assign wr_en       = req_valid & req_we;
    assign rd_en       = req_valid & ~req_we;
    assign en          = ctrl[CTRL_EN_BIT];
    assign edge_mode   = ctrl[CTRL_EDGE_BIT];
    assign tick        = en && (presc == PRESCALE_MAX);

    irq_sync u_ext_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_irq_in),
        .level    (ext_level),
        .rise     (ext_rise)
    );

    // A written half overrides the incremented value; the unwritten half keeps
    // its increment, so a carry out of lo survives a lo write but not a hi write.
    always_comb begin
        mtime_inc     = mtime + 64'(tick);
        mtime_lo_next = (wr_en && idx == REG_MTIME_LO) ? req_wdata : mtime_inc[31:0];
        mtime_hi_next = (wr_en && idx == REG_MTIME_HI) ? req_wdata : mtime_inc[63:32];
    end

    always_comb begin
        pend_clr = ext_ack | (wr_en && idx == REG_STATUS && req_wdata[STATUS_PEND_BIT]);
        if (!edge_mode) begin
            pend_next = ext_level;
        end else if (ext_rise) begin
            pend_next = 1'b1;
        end else if (pend_clr) begin
            pend_next = 1'b0;
        end else begin
            pend_next = pending;
        end
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_MTIME_LO:    rd_data = mtime[31:0];
            REG_MTIME_HI:    rd_data = mtime[63:32];
            REG_MTIMECMP_LO: rd_data = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_data = mtimecmp[63:32];
            REG_CTRL:        rd_data = {30'd0, ctrl};
            REG_STATUS:      rd_data = {31'd0, pending};
            default:         rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            mtime     <= MTIME_RST;
            mtimecmp  <= MTIMECMP_RST;
            ctrl      <= '0;
            pending   <= 1'b0;
            ti        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (en) begin
                presc <= tick ? '0 : presc + presc_t'(1);
            end
            mtime <= {mtime_hi_next, mtime_lo_next};
            if (wr_en && idx == REG_MTIMECMP_LO) begin
                mtimecmp[31:0] <= req_wdata;
            end
            if (wr_en && idx == REG_MTIMECMP_HI) begin
                mtimecmp[63:32] <= req_wdata;
            end
            if (wr_en && idx == REG_CTRL) begin
                ctrl <= req_wdata[1:0];
            end
            pending   <= pend_next;
            ti        <= (mtime >= mtimecmp);
            rsp_valid <= req_valid;
            rsp_rdata <= rd_en ? rd_data : '0;
        end
    end

    assign ei = edge_mode ? pending : ext_level;

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter PRESCALE, default 1: clk cycles per mtime tick; legal range 1..65535.
REQ-002 clk  input  1  Core clock; all state on its rising edge.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 ext_irq_in  input  1  External interrupt request, asynchronous to clk.
REQ-005 ext_ack  input  1  One-cycle pulse that clears the pending external interrupt (handler claim).
REQ-006 req_valid  input  1  Bus access request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read; full-word accesses only.
REQ-008 req_addr  input  5  Byte offset; bits [1:0] ignored.
REQ-009 req_wdata  input  32  Write data.
REQ-010 rsp_valid  output  1  Read or write response, one cycle after req_valid.
REQ-011 rsp_rdata  output  32  Read data; 0 for writes and unmapped offsets.
REQ-012 ei  output  1  External interrupt to the core's ei input.
REQ-013 ti  output  1  Timer interrupt to the core's ti input.

Function
REQ-014 Register map: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 ctrl, 0x14 status; 0x18-0x1C unmapped (reads 0, writes ignored).
REQ-015 ctrl bit0 = timer enable, bit1 = ext edge mode (1 = edge, 0 = level); other bits read 0.
REQ-016 status bit0 = ext pending; writing 1 clears it, writing 0 has no effect; other bits read 0.
REQ-017 A 16-bit prescaler counts while enable=1; on reaching PRESCALE-1 it wraps to 0 and mtime increments by 1.
REQ-018 Prescaler holds its value while enable=0; mtime never changes while enable=0 except by bus write.
REQ-019 mtime is 64-bit; carry propagates from lo into hi; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-020 Bus write to one mtime half replaces that half; the other half takes its normally updated value, except that a carry into the written half is discarded.
REQ-021 Read latency: rsp_rdata is valid with rsp_valid exactly one cycle after req_valid; it reflects register contents before any same-cycle write.
REQ-022 ti is registered: ti = 1 in the cycle after mtime >= mtimecmp (unsigned 64-bit) holds; it is independent of enable.
REQ-023 ext_irq_in passes through a 2-flop synchronizer before any use.
REQ-024 Level mode: ei = synchronized level; pending bit tracks that level.
REQ-025 Edge mode: a synchronized 0->1 transition sets pending; ei = pending.
REQ-026 Pending clears on ext_ack or status W1C; if a set and a clear occur in the same cycle, set wins.
REQ-027 Changing mode bit leaves pending unchanged; the edge detector re-arms on the current synchronized level, with no spurious edge.

Reset
REQ-028 Reset values: mtime = 0, prescaler = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF, ctrl = 0, pending = 0, synchronizer flops = 0.
REQ-029 Output reset values: ei = 0, ti = 0, rsp_valid = 0, rsp_rdata = 0.
REQ-030 Reset asserted mid-access drops the response; no rsp_valid is issued for a request accepted before reset.

Structure
REQ-031 Package clint_pkg holds the register offsets, ctrl/status bit positions, and the mtime/mtimecmp reset constants.
REQ-032 Sub-module irq_sync: 2-flop synchronizer plus rising-edge detector, instantiated once for ext_irq_in.

Verification
REQ-033 Reset; write mtimecmp = 5, ctrl = 1, PRESCALE = 1 -> ti rises the cycle after mtime reaches 5; ti stays 0 while mtime = 0..4.
REQ-034 PRESCALE = 4; mtime_lo = 0xFFFF_FFFF, enable -> after 4 cycles mtime_hi = 1 and mtime_lo = 0.
REQ-035 Write mtime_hi = 7 in the same cycle lo wraps -> hi = 7, not 8.
REQ-036 Edge mode; pulse ext_irq_in for 3 cycles -> ei = 1 by the third cycle after the rise and stays 1 after the input falls; ext_ack -> ei = 0 next cycle.
REQ-037 Edge in the same cycle as ext_ack -> pending remains 1.
REQ-038 Read 0x08 in the same cycle as a write 0x08 = 0x1234 -> rsp_rdata = 0xFFFF_FFFF; the next read returns 0x1234.
